smm_tile_sequencer: RTL and testbench

Upstream sequencer for the 4x4 Strassen matrix-multiply stage.
- Collects operand matrices A and B row-by-row from two valid/ready streams and packs them into the flat operand buses.
- Issues a one-cycle load with the latched mode on sel, then waits a fixed compute latency and captures the product bus.
- Streams the result back out row-by-row. One job is in flight at a time.

---
 rtl/smm_tile_sequencer.sv | 126 ++++++++++++
 tb/tb_smm_tile_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/smm_tile_sequencer.sv
// Operand collector and result streamer for the 4x4 Strassen multiply stage.
// Gathers A/B rows, pulses load, waits a fixed latency, then drains C row by row.
//
// state | meaning
// FILL  | accepting A and B rows until both matrices hold 4 rows
// ISSUE | one-cycle load strobe to the multiply stage
// WAIT  | counting compute latency, captures C_in on the last count
// DRAIN | streaming result rows out, back to FILL after row 3
module smm_tile_sequencer #(
    parameter int DATAWIDTH = 32,
    parameter int BLOCKSIZE = DATAWIDTH * 4,
    parameter int BUSWIDTH  = BLOCKSIZE * 4,
    parameter int LATENCY   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 a_row_valid,
    output logic                 a_row_ready,
    input  logic [BLOCKSIZE-1:0] a_row_data,
    input  logic                 b_row_valid,
    output logic                 b_row_ready,
    input  logic [BLOCKSIZE-1:0] b_row_data,
    output logic [BUSWIDTH-1:0]  A,
    output logic [BUSWIDTH-1:0]  B,
    output logic                 load,
    output logic                 sel,
    input  logic [BUSWIDTH-1:0]  C_in,
    output logic                 c_row_valid,
    input  logic                 c_row_ready,
    output logic [BLOCKSIZE-1:0] c_row_data,
    output logic                 busy
);
    localparam int WCW = ($clog2(LATENCY + 1) < 1) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {FILL, ISSUE, WAIT, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [2:0]          a_cnt, b_cnt;
    logic [WCW-1:0]      wait_cnt;
    logic [1:0]          row_idx;
    logic [BUSWIDTH-1:0] result;
    logic                a_fire, b_fire, c_fire;
    logic                fill_done, wait_done, drain_done;

    assign a_row_ready = (state == FILL) && (a_cnt < 3'd4);
    assign b_row_ready = (state == FILL) && (b_cnt < 3'd4);
    assign a_fire      = a_row_valid && a_row_ready;
    assign b_fire      = b_row_valid && b_row_ready;
    assign c_fire      = c_row_valid && c_row_ready;

    // Leave FILL right after the fourth beat of the slower stream lands
    assign fill_done  = ((a_cnt == 3'd4) || ((a_cnt == 3'd3) && a_fire)) &&
                        ((b_cnt == 3'd4) || ((b_cnt == 3'd3) && b_fire));
    assign wait_done  = (wait_cnt == WCW'(LATENCY));
    assign drain_done = c_fire && (row_idx == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FILL;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:    if (fill_done)  state_nxt = ISSUE;
            ISSUE:                   state_nxt = WAIT;
            WAIT:    if (wait_done)  state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = FILL;
            default:                 state_nxt = FILL;
        endcase
    end

    always_comb begin
        load        = (state == ISSUE);
        c_row_valid = (state == DRAIN);
        c_row_data  = result[row_idx*BLOCKSIZE +: BLOCKSIZE];
        busy        = !((state == FILL) && (a_cnt == 3'd0) && (b_cnt == 3'd0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_cnt    <= '0;
            b_cnt    <= '0;
            wait_cnt <= '0;
            row_idx  <= '0;
            A        <= '0;
            B        <= '0;
            result   <= '0;
            sel      <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (a_fire) begin
                        A[a_cnt[1:0]*BLOCKSIZE +: BLOCKSIZE] <= a_row_data;
                        a_cnt <= a_cnt + 3'd1;
                        if (a_cnt == 3'd0) sel <= mode;
                    end
                    if (b_fire) begin
                        B[b_cnt[1:0]*BLOCKSIZE +: BLOCKSIZE] <= b_row_data;
                        b_cnt <= b_cnt + 3'd1;
                    end
                end
                ISSUE: wait_cnt <= WCW'(1);
                WAIT: begin
                    if (wait_done) begin
                        result  <= C_in;
                        row_idx <= 2'd0;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                DRAIN: begin
                    if (c_fire) begin
                        row_idx <= row_idx + 2'd1;
                        if (row_idx == 2'd3) begin
                            a_cnt <= '0;
                            b_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_smm_tile_sequencer.sv
// Bench for smm_tile_sequencer: instance 0 uses LATENCY=3, instance 1 LATENCY=1.
// Each instance has a behavioral multiplier stub that presents C only in the capture cycle.
module tb_smm_tile_sequencer;
    localparam int DW  = 32;
    localparam int BLK = DW * 4;
    localparam int BUS = BLK * 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           mode_i [2];
    logic           a_vld  [2];
    logic           a_rdy  [2];
    logic           b_vld  [2];
    logic           b_rdy  [2];
    logic           load   [2];
    logic           sel    [2];
    logic           c_vld  [2];
    logic           c_rdy  [2];
    logic           busy   [2];
    logic [BLK-1:0] a_dat  [2];
    logic [BLK-1:0] b_dat  [2];
    logic [BLK-1:0] c_dat  [2];
    logic [BUS-1:0] a_bus  [2];
    logic [BUS-1:0] b_bus  [2];
    logic [BUS-1:0] c_in   [2];

    logic [BLK-1:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [BUS-1:0] matmul(input logic [BUS-1:0] a, input logic [BUS-1:0] b);
        logic [BUS-1:0] c;
        logic [DW-1:0]  acc, ea, eb;
        c = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    ea  = a[(r*4+j)*DW +: DW];
                    eb  = b[(j*4+k)*DW +: DW];
                    acc = acc + ea * eb;
                end
                c[(r*4+k)*DW +: DW] = acc;
            end
        end
        return c;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 3 : 1;
        int             scnt;
        logic [BUS-1:0] sprod;

        smm_tile_sequencer #(.DATAWIDTH(DW), .LATENCY(LAT)) dut (
            .clk(clk), .rst(rst), .mode(mode_i[g]),
            .a_row_valid(a_vld[g]), .a_row_ready(a_rdy[g]), .a_row_data(a_dat[g]),
            .b_row_valid(b_vld[g]), .b_row_ready(b_rdy[g]), .b_row_data(b_dat[g]),
            .A(a_bus[g]), .B(b_bus[g]), .load(load[g]), .sel(sel[g]), .C_in(c_in[g]),
            .c_row_valid(c_vld[g]), .c_row_ready(c_rdy[g]), .c_row_data(c_dat[g]),
            .busy(busy[g])
        );

        // Product is valid only in the cycle LAT after load; garbage elsewhere
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                scnt  <= 0;
                sprod <= '0;
            end else if (load[g]) begin
                scnt  <= 1;
                sprod <= matmul(a_bus[g], b_bus[g]);
            end else if (scnt == LAT) begin
                scnt <= 0;
            end else if (scnt != 0) begin
                scnt <= scnt + 1;
            end
        end
        assign c_in[g] = (scnt == LAT) ? sprod : {16{32'hDEADBEEF}};
    end

    task automatic chk(input string tag, input logic [BUS-1:0] got, input logic [BUS-1:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    function automatic logic [BUS-1:0] rand_mat();
        logic [BUS-1:0] m;
        for (int i = 0; i < 16; i++) m[i*DW +: DW] = $urandom;
        return m;
    endfunction

    task automatic send_job(input int d, input logic [BUS-1:0] am, input logic [BUS-1:0] bm,
                            input logic m0, input bit b_after_a, input int bgap, input int exp_cyc);
        logic [BUS-1:0] prod;
        int ai = 0, bi = 0, bwait = 0, cyc = 0;
        prod = matmul(am, bm);
        for (int r = 0; r < 4; r++) exp_q.push_back(prod[r*BLK +: BLK]);
        while ((ai < 4 || bi < 4) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (b_after_a && ai == 4 && bi < 4) begin
                chk("a_rdy_after_4th", BUS'(a_rdy[d]), BUS'(0));
                chk("a_bus_during_b", a_bus[d], am);
            end
            a_vld[d]  = (ai < 4);
            mode_i[d] = (ai == 0) ? m0 : !m0;
            if (ai < 4) a_dat[d] = am[ai*BLK +: BLK];
            b_vld[d] = (bi < 4) && (bwait == 0) && (!b_after_a || ai == 4);
            if (bi < 4) b_dat[d] = bm[bi*BLK +: BLK];
            if (a_vld[d] && a_rdy[d]) ai++;
            if (b_vld[d] && b_rdy[d]) begin
                bi++;
                bwait = bgap;
            end else if (bwait > 0) begin
                bwait--;
            end
        end
        chk("fill_complete", BUS'(ai + bi), BUS'(8));
        if (exp_cyc > 0) chk("fill_cycles", BUS'(cyc), BUS'(exp_cyc));
        @(negedge clk);
        a_vld[d] = 1'b0;
        b_vld[d] = 1'b0;
        chk("load_issue", BUS'(load[d]), BUS'(1));
        chk("a_bus_issue", a_bus[d], am);
        chk("b_bus_issue", b_bus[d], bm);
        chk("sel_issue", BUS'(sel[d]), BUS'(m0));
        chk("busy_issue", BUS'(busy[d]), BUS'(1));
        @(negedge clk);
        chk("load_after_issue", BUS'(load[d]), BUS'(0));
    endtask

    task automatic drain(input int d, input int stall, input bit toggle, input logic exp_sel);
        int n = 0, cyc = 0, sc = 0;
        bit ph = 1'b1, seen = 1'b0;
        logic [BLK-1:0] r0, exp_row;
        while (n < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            chk("in_rdy_low", BUS'({a_rdy[d], b_rdy[d]}), BUS'(0));
            if (c_vld[d]) begin
                chk("sel_drain", BUS'(sel[d]), BUS'(exp_sel));
                if (!seen) begin
                    seen = 1'b1;
                    r0   = c_dat[d];
                end
                if (sc < stall) begin
                    if (sc > 0) chk("stall_row0", BUS'(c_dat[d]), BUS'(r0));
                    sc++;
                    c_rdy[d] = 1'b0;
                end else if (toggle) begin
                    c_rdy[d] = ph;
                    ph = !ph;
                end else begin
                    c_rdy[d] = 1'b1;
                end
                if (c_rdy[d]) begin
                    if (exp_q.size() == 0) begin
                        chk("c_row_unexpected", BUS'(1), BUS'(0));
                    end else begin
                        exp_row = exp_q.pop_front();
                        chk("c_row", BUS'(c_dat[d]), BUS'(exp_row));
                    end
                    n++;
                end
            end else begin
                c_rdy[d] = 1'b0;
            end
        end
        chk("drain_beats", BUS'(n), BUS'(4));
        @(negedge clk);
        c_rdy[d] = 1'b0;
        chk("c_valid_drop", BUS'(c_vld[d]), BUS'(0));
        chk("in_rdy_after", BUS'({a_rdy[d], b_rdy[d]}), BUS'(3));
        chk("busy_after", BUS'(busy[d]), BUS'(0));
    endtask

    initial begin
        logic [BUS-1:0] ident, seq, m1, m2, ex_a, ex_b;
        int bad;
        for (int i = 0; i < 2; i++) begin
            mode_i[i] = 1'b0; a_vld[i] = 1'b0; b_vld[i] = 1'b0; c_rdy[i] = 1'b0;
            a_dat[i] = '0; b_dat[i] = '0;
        end
        ident = '0;
        seq   = '0;
        for (int i = 0; i < 16; i++) seq[i*DW +: DW] = DW'(i + 1);
        for (int r = 0; r < 4; r++) ident[(r*4+r)*DW +: DW] = 32'd1;

        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_load", BUS'(load[0]), BUS'(0));
        chk("rst_c_valid", BUS'(c_vld[0]), BUS'(0));
        chk("rst_a_bus", a_bus[0], '0);
        chk("rst_b_bus", b_bus[0], '0);
        chk("rst_c_data", BUS'(c_dat[0]), '0);
        chk("rst_busy", BUS'(busy[0]), BUS'(0));
        chk("rst_in_rdy", BUS'({a_rdy[0], b_rdy[0]}), BUS'(3));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("load_after_rst_release", BUS'(load[0]), BUS'(0));

        // identity x 1..16, both streams back to back
        send_job(0, ident, seq, 1'b0, 1'b0, 0, 4);
        drain(0, 0, 1'b0, 1'b0);

        // A first then B with 2-cycle gaps, mode 1, stalled then toggling sink
        m1 = rand_mat();
        m2 = rand_mat();
        send_job(0, m1, m2, 1'b1, 1'b1, 2, -1);
        drain(0, 5, 1'b1, 1'b1);

        // next job with mode 0 must clear sel
        m1 = rand_mat();
        m2 = rand_mat();
        send_job(0, m1, m2, 1'b0, 1'b0, 1, -1);
        drain(0, 0, 1'b1, 1'b0);

        // reset pulse while waiting on the multiplier
        send_job(0, rand_mat(), rand_mat(), 1'b1, 1'b0, 0, 4);
        rst = 1'b0;
        #1;
        chk("wrst_load", BUS'(load[0]), BUS'(0));
        chk("wrst_c_valid", BUS'(c_vld[0]), BUS'(0));
        chk("wrst_a_bus", a_bus[0], '0);
        chk("wrst_b_bus", b_bus[0], '0);
        chk("wrst_sel", BUS'(sel[0]), BUS'(0));
        @(negedge clk);
        rst = 1'b1;
        chk("wrst_in_rdy", BUS'({a_rdy[0], b_rdy[0]}), BUS'(3));
        chk("wrst_busy", BUS'(busy[0]), BUS'(0));
        exp_q.delete();
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            c_rdy[0] = 1'b1;
            if (c_vld[0] || load[0]) bad++;
        end
        c_rdy[0] = 1'b0;
        chk("no_beat_after_rst", BUS'(bad), BUS'(0));

        // recovery job after reset
        send_job(0, rand_mat(), ident, 1'b0, 1'b0, 0, 4);
        drain(0, 0, 1'b0, 1'b0);

        // extreme values through the LATENCY=1 instance
        ex_a = '0;
        ex_b = '0;
        for (int i = 0; i < 16; i++) begin
            ex_a[i*DW +: DW] = (i % 3 == 0) ? 32'hFFFFFFFF : 32'h80000000;
            ex_b[i*DW +: DW] = (i % 2 == 0) ? 32'h80000000 : 32'hFFFFFFFF;
        end
        send_job(1, ex_a, ex_b, 1'b1, 1'b0, 0, 4);
        drain(1, 2, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
